// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and pattern constant for the 1011 detector
package seq_det_pkg;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter that holds at all-ones; sync active-high clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (en && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/modport_1011_detector.sv
// rtl/modport_1011_detector.sv - Moore detector for serial pattern 1011, MSB first
// Optional saturating match counter on det_count when SEQ_DET_CNT_EN is defined.
module modport_1011_detector
  import seq_det_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
`ifdef SEQ_DET_CNT_EN
  output logic [CNT_W-1:0] det_count,
`endif
  output logic             dout
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e r_state;
  state_e w_next_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S0;
    case (r_state)
      S0:    w_next_state = din ? S1    : S0;
      S1:    w_next_state = din ? S1    : S10;
      S10:   w_next_state = din ? S101  : S0;
      S101:  w_next_state = din ? S1011 : S10;
      // Overlap keeps the trailing "10" of ...10110 as a fresh prefix.
      S1011: w_next_state = din ? S1 : ((OVERLAP != 0) ? S10 : S0);
      default: w_next_state = S0;
    endcase
  end

  assign dout = (r_state == S1011);

`ifdef SEQ_DET_CNT_EN
  logic w_cnt_en;

  assign w_cnt_en = (w_next_state == S1011);

  sat_counter #(
    .W(CNT_W)
  ) u_sat_counter (
    .clk(clk),
    .rst(rst),
    .en (w_cnt_en),
    .q  (det_count)
  );
`endif

endmodule

// File: tb/tb_modport_1011_detector.sv
// tb/tb_modport_1011_detector.sv - directed and random checks of the 1011 detector
module tb_modport_1011_detector;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout_ov;
  logic dout_no;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] cnt_ov;
  logic [1:0] cnt_no;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] hist_ov, hist_no;
  int         n_ov, n_no;
  logic       exp_ov, exp_no;
  int         mcnt_ov, mcnt_no;

  always #5 clk = ~clk;

  modport_1011_detector #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
`ifdef SEQ_DET_CNT_EN
    .det_count(cnt_ov),
`endif
    .dout     (dout_ov)
  );

  modport_1011_detector #(.OVERLAP(0), .CNT_W(2)) dut_no (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
`ifdef SEQ_DET_CNT_EN
    .det_count(cnt_no),
`endif
    .dout     (dout_no)
  );

  task automatic step(input logic b);
    din = b;
    @(posedge clk);
    if (rst) begin
      n_ov = 0; n_no = 0; hist_ov = '0; hist_no = '0;
      exp_ov = 1'b0; exp_no = 1'b0; mcnt_ov = 0; mcnt_no = 0;
    end else begin
      hist_ov = {hist_ov[2:0], b};
      if (n_ov < 4) n_ov++;
      exp_ov = (n_ov == 4) && (hist_ov == PATTERN);
      if (exp_ov && mcnt_ov < 255) mcnt_ov++;
      hist_no = {hist_no[2:0], b};
      if (n_no < 4) n_no++;
      exp_no = (n_no == 4) && (hist_no == PATTERN);
      if (exp_no) begin
        n_no = 0;
        if (mcnt_no < 3) mcnt_no++;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      checks++;
      if (dout_ov !== 1'b0) begin errors++; $display("FAIL reset_dout_ov got=%b exp=0", dout_ov); end
      checks++;
      if (dout_no !== 1'b0) begin errors++; $display("FAIL reset_dout_no got=%b exp=0", dout_no); end
`ifdef SEQ_DET_CNT_EN
      checks++;
      if (cnt_ov !== 8'd0) begin errors++; $display("FAIL reset_cnt_ov got=%0d exp=0", cnt_ov); end
      checks++;
      if (cnt_no !== 2'd0) begin errors++; $display("FAIL reset_cnt_no got=%0d exp=0", cnt_no); end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [5:0] bits;
    logic [5:0] e;
    bits = 6'b101100;
    e    = 6'b000100;
    apply_reset();
    for (int i = 5; i >= 0; i--) begin
      step(bits[i]);
      checks++;
      if (dout_ov !== e[i]) begin errors++; $display("FAIL single_ov bit%0d got=%b exp=%b", 5-i, dout_ov, e[i]); end
      checks++;
      if (dout_no !== e[i]) begin errors++; $display("FAIL single_no bit%0d got=%b exp=%b", 5-i, dout_no, e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    logic [7:0] e_ov;
    logic [7:0] e_no;
    bits = 8'b10110110;
    e_ov = 8'b00010010;
    e_no = 8'b00010000;
    apply_reset();
    for (int i = 7; i >= 0; i--) begin
      step(bits[i]);
      checks++;
      if (dout_ov !== e_ov[i]) begin errors++; $display("FAIL b2b_ov bit%0d got=%b exp=%b", 7-i, dout_ov, e_ov[i]); end
      checks++;
      if (dout_no !== e_no[i]) begin errors++; $display("FAIL b2b_no bit%0d got=%b exp=%b", 7-i, dout_no, e_no[i]); end
    end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (cnt_ov !== 8'd2) begin errors++; $display("FAIL b2b_cnt_ov got=%0d exp=2", cnt_ov); end
    checks++;
    if (cnt_no !== 2'd1) begin errors++; $display("FAIL b2b_cnt_no got=%0d exp=1", cnt_no); end
`endif
  endtask

  task automatic test_no_double();
    logic [7:0] bits;
    logic [7:0] e;
    bits = 8'b10111011;
    e    = 8'b00010001;
    apply_reset();
    for (int i = 7; i >= 0; i--) begin
      step(bits[i]);
      checks++;
      if (dout_ov !== e[i]) begin errors++; $display("FAIL nodbl_ov bit%0d got=%b exp=%b", 7-i, dout_ov, e[i]); end
      checks++;
      if (dout_no !== e[i]) begin errors++; $display("FAIL nodbl_no bit%0d got=%b exp=%b", 7-i, dout_no, e[i]); end
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] bits;
    logic [7:0] r;
    logic [7:0] e;
    bits = 8'b10111011;
    r    = 8'b00010000;
    e    = 8'b00000001;
    apply_reset();
    for (int i = 7; i >= 0; i--) begin
      rst = r[i];
      step(bits[i]);
      checks++;
      if (dout_ov !== e[i]) begin errors++; $display("FAIL rstmid_ov bit%0d got=%b exp=%b", 7-i, dout_ov, e[i]); end
      checks++;
      if (dout_no !== e[i]) begin errors++; $display("FAIL rstmid_no bit%0d got=%b exp=%b", 7-i, dout_no, e[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    logic [5:0] bits;
    logic [5:0] e;
    int pulses_ov;
    int pulses_no;
    bits = 6'b101100;
    e    = 6'b000100;
    pulses_ov = 0;
    pulses_no = 0;
    apply_reset();
    for (int m = 0; m < 5; m++) begin
      for (int i = 5; i >= 0; i--) begin
        step(bits[i]);
        if (dout_ov === 1'b1) pulses_ov++;
        if (dout_no === 1'b1) pulses_no++;
        checks++;
        if (dout_ov !== e[i]) begin errors++; $display("FAIL sat_ov m%0d bit%0d got=%b exp=%b", m, 5-i, dout_ov, e[i]); end
      end
    end
    checks++;
    if (pulses_no !== 5) begin errors++; $display("FAIL sat_pulses_no got=%0d exp=5", pulses_no); end
    checks++;
    if (pulses_ov !== 5) begin errors++; $display("FAIL sat_pulses_ov got=%0d exp=5", pulses_ov); end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (cnt_no !== 2'd3) begin errors++; $display("FAIL sat_cnt_no got=%0d exp=3", cnt_no); end
    checks++;
    if (cnt_ov !== 8'd5) begin errors++; $display("FAIL sat_cnt_ov got=%0d exp=5", cnt_ov); end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(1'($urandom_range(0, 1)));
      checks++;
      if (dout_ov !== exp_ov) begin errors++; $display("FAIL rand_ov cyc%0d got=%b exp=%b", i, dout_ov, exp_ov); end
      checks++;
      if (dout_no !== exp_no) begin errors++; $display("FAIL rand_no cyc%0d got=%b exp=%b", i, dout_no, exp_no); end
`ifdef SEQ_DET_CNT_EN
      checks++;
      if (cnt_ov !== 8'(mcnt_ov)) begin errors++; $display("FAIL rand_cnt_ov cyc%0d got=%0d exp=%0d", i, cnt_ov, mcnt_ov); end
      checks++;
      if (cnt_no !== 2'(mcnt_no)) begin errors++; $display("FAIL rand_cnt_no cyc%0d got=%0d exp=%0d", i, cnt_no, mcnt_no); end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    n_ov = 0; n_no = 0; hist_ov = '0; hist_no = '0;
    exp_ov = 1'b0; exp_no = 1'b0; mcnt_ov = 0; mcnt_no = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_no_double();
    test_rst_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
